cache_wb_controller: RTL and testbench

- Clocked, FSM-sequenced direct-mapped write-back cache controller: 1 KB byte-addressed space, 4 lines of 16 bytes each.
- Owns the tag/valid/dirty/data arrays. Serves single-byte CPU reads and writes.
- Sequences victim write-back and line refill over a 128-bit memory port with a req/ack handshake.
- Sits between the CPU byte port and main memory. Replaces the unclocked, delay-based miss handling.

---
 rtl/cache_pkg.sv | 26 ++
 rtl/cache_line_store.sv | 51 +++++
 rtl/cache_wb_controller.sv | 154 +++++++++++++++
 tb/tb_cache_wb_controller.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared address slicing, FSM encoding and line-address helper for the
// 1 KB direct-mapped write-back cache (4 lines x 16 bytes).
package cache_pkg;
  localparam int ADDR_W  = 10;
  localparam int TAG_W   = 4;
  localparam int IDX_W   = 2;
  localparam int OFF_W   = 4;
  localparam int BYTE_W  = 8;
  localparam int LINE_W  = (1 << OFF_W) * BYTE_W;
  localparam int LINES   = 1 << IDX_W;
  localparam int IDX_LSB = OFF_W;
  localparam int TAG_LSB = OFF_W + IDX_W;
  localparam int BYTE_SH = $clog2(BYTE_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMPARE,
    ST_WRITEBACK,
    ST_ALLOCATE
  } state_t;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFF_W{1'b0}}};
  endfunction
endpackage

// File: rtl/cache_line_store.sv
// Tag/valid/dirty/data arrays with combinational read of the indexed line.
// Line fill has priority over byte write; everything clears on clr_n.
module cache_line_store
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              clr_n,
  input  logic [IDX_W-1:0]  idx,
  input  logic              byte_we,
  input  logic [OFF_W-1:0]  byte_off,
  input  logic [BYTE_W-1:0] byte_data,
  input  logic              line_we,
  input  logic [TAG_W-1:0]  line_tag,
  input  logic [LINE_W-1:0] line_data,
  input  logic              clean_we,
  output logic [LINE_W-1:0] rd_data,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  output logic              rd_dirty
);
  logic [LINE_W-1:0] data_q [LINES];
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < LINES; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      data_q[idx]  <= line_data;
      tag_q[idx]   <= line_tag;
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (byte_we) begin
      data_q[idx][{byte_off, {BYTE_SH{1'b0}}} +: BYTE_W] <= byte_data;
      dirty_q[idx] <= 1'b1;
    end else if (clean_we) begin
      dirty_q[idx] <= 1'b0;
    end
  end

  assign rd_data  = data_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
endmodule

// File: rtl/cache_wb_controller.sv
// Direct-mapped write-back cache controller: hit completes 2 cycles after cpu_req,
// misses add write-back/refill waits; cpu_req ignored while busy, mem_* held until mem_ack.
module cache_wb_controller
  import cache_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_row,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [BYTE_W-1:0] cpu_wdata,
  output logic [BYTE_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_hit,
  output logic              mem_req,
  output logic              mem_row,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);
  state_t state, state_d;

  logic [ADDR_W-1:0] req_addr;
  logic              req_row;
  logic [BYTE_W-1:0] req_wdata;
  logic              first_miss;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [OFF_W-1:0]  req_off;

  logic [LINE_W-1:0] line_data;
  logic [TAG_W-1:0]  line_tag;
  logic              line_valid;
  logic              line_dirty;

  logic hit, mem_done, latch_req, byte_we, line_we, clean_we;

  assign req_tag = req_addr[TAG_LSB +: TAG_W];
  assign req_idx = req_addr[IDX_LSB +: IDX_W];
  assign req_off = req_addr[OFF_W-1:0];

  cache_line_store u_store (
    .clk       (clk),
    .clr_n     (rst_n),
    .idx       (req_idx),
    .byte_we   (byte_we),
    .byte_off  (req_off),
    .byte_data (req_wdata),
    .line_we   (line_we),
    .line_tag  (req_tag),
    .line_data (mem_rdata),
    .clean_we  (clean_we),
    .rd_data   (line_data),
    .rd_tag    (line_tag),
    .rd_valid  (line_valid),
    .rd_dirty  (line_dirty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    hit       = line_valid && (line_tag == req_tag);
    mem_done  = mem_req && mem_ack;
    latch_req = 1'b0;
    byte_we   = 1'b0;
    line_we   = 1'b0;
    clean_we  = 1'b0;
    case (state)
      ST_IDLE: begin
        latch_req = cpu_req;
        if (cpu_req) state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        byte_we = hit && req_row;
        if (hit)                          state_d = ST_IDLE;
        else if (line_valid && line_dirty) state_d = ST_WRITEBACK;
        else                               state_d = ST_ALLOCATE;
      end
      ST_WRITEBACK: begin
        clean_we = mem_done;
        if (mem_done) state_d = ST_ALLOCATE;
      end
      ST_ALLOCATE: begin
        line_we = mem_done;
        if (mem_done) state_d = ST_COMPARE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr   <= '0;
      req_row    <= 1'b0;
      req_wdata  <= '0;
      first_miss <= 1'b0;
      cpu_rdata  <= '0;
      cpu_ready  <= 1'b0;
      cpu_hit    <= 1'b0;
      mem_req    <= 1'b0;
      mem_row    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      cpu_ready <= 1'b0;
      cpu_hit   <= 1'b0;

      if (latch_req) begin
        req_addr   <= cpu_addr;
        req_row    <= cpu_row;
        req_wdata  <= cpu_wdata;
        first_miss <= 1'b0;
      end

      if (state == ST_COMPARE) begin
        if (hit) begin
          cpu_ready <= 1'b1;
          cpu_hit   <= !first_miss;
          if (!req_row) cpu_rdata <= line_data[{req_off, {BYTE_SH{1'b0}}} +: BYTE_W];
          if (!first_miss && hit_count != '1) hit_count <= hit_count + 1'b1;
        end else begin
          first_miss <= 1'b1;
          if (miss_count != '1) miss_count <= miss_count + 1'b1;
        end
      end

      // mem_* are loaded on entry to each memory state so they are stable for the whole wait
      if (state_d == ST_WRITEBACK && state != ST_WRITEBACK) begin
        mem_req   <= 1'b1;
        mem_row   <= 1'b1;
        mem_addr  <= line_addr(line_tag, req_idx);
        mem_wdata <= line_data;
      end else if (state_d == ST_ALLOCATE && state != ST_ALLOCATE) begin
        mem_req  <= 1'b1;
        mem_row  <= 1'b0;
        mem_addr <= line_addr(req_tag, req_idx);
      end else if (state == ST_ALLOCATE && mem_done) begin
        mem_req <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cache_wb_controller.sv
// Randomized scoreboard bench: flat-memory reference model predicts CPU responses and memory traffic.
`timescale 1ns/1ps
module tb_cache_wb_controller;
  import cache_pkg::*;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cpu_req = 1'b0;
  logic              cpu_row = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [BYTE_W-1:0] cpu_wdata = '0;
  logic [BYTE_W-1:0] cpu_rdata;
  logic              cpu_ready, cpu_hit;
  logic              mem_req, mem_row;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata = '0;
  logic              mem_ack = 1'b0;
  logic [CNT_W-1:0]  hit_count, miss_count;

  always #5 clk = ~clk;

  cache_wb_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_row(cpu_row), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_hit(cpu_hit),
    .mem_req(mem_req), .mem_row(mem_row), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  typedef struct {
    logic       is_read;
    logic [7:0] rdata;
    logic       hit;
    int         hits;
    int         misses;
    int         issue_cyc;
  } cpu_exp_t;

  typedef struct {
    logic         row;
    logic [9:0]   addr;
    logic [127:0] wdata;
  } mem_exp_t;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int fixed_lat = -1;

  logic [7:0] mem   [1024];
  logic [7:0] truth [1024];
  logic       m_valid [4];
  logic       m_dirty [4];
  int         m_tag   [4];
  int         m_hits, m_misses;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [127:0] truth_line(input int base);
    logic [127:0] l;
    for (int k = 0; k < 16; k++) l[8*k +: 8] = truth[base + k];
    return l;
  endfunction

  function automatic logic [127:0] mem_line(input int base);
    logic [127:0] l;
    for (int k = 0; k < 16; k++) l[8*k +: 8] = mem[base + k];
    return l;
  endfunction

  // After reset the cache is empty, so the visible contents are just main memory.
  task automatic model_reset();
    for (int i = 0; i < 1024; i++) truth[i] = mem[i];
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = 0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic model_req(input logic row, input int addr, input logic [7:0] wd);
    int idx, tag;
    logic h;
    cpu_exp_t e;
    mem_exp_t m;
    idx = (addr / 16) % 4;
    tag = addr / 64;
    h = m_valid[idx] && (m_tag[idx] == tag);
    if (h) begin
      if (m_hits < CNT_MAX) m_hits++;
    end else begin
      if (m_misses < CNT_MAX) m_misses++;
      if (m_valid[idx] && m_dirty[idx]) begin
        m.row   = 1'b1;
        m.addr  = 10'(m_tag[idx] * 64 + idx * 16);
        m.wdata = truth_line(m_tag[idx] * 64 + idx * 16);
        mem_q.push_back(m);
      end
      m.row   = 1'b0;
      m.addr  = 10'(tag * 64 + idx * 16);
      m.wdata = '0;
      mem_q.push_back(m);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_dirty[idx] = 1'b0;
    end
    if (row) begin
      truth[addr]  = wd;
      m_dirty[idx] = 1'b1;
    end
    e.is_read   = !row;
    e.rdata     = truth[addr];
    e.hit       = h;
    e.hits      = m_hits;
    e.misses    = m_misses;
    e.issue_cyc = cyc;
    cpu_q.push_back(e);
  endtask

  task automatic issue(input logic row, input int addr, input logic [7:0] wd);
    @(posedge clk); #1;
    model_req(row, addr, wd);
    cpu_req   = 1'b1;
    cpu_row   = row;
    cpu_addr  = 10'(addr);
    cpu_wdata = wd;
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < target) fail_now("ready_timeout");
  endtask

  task automatic txn(input logic row, input int addr, input logic [7:0] wd);
    int target;
    target = done_cnt + 1;
    issue(row, addr, wd);
    wait_done(target);
  endtask

  task automatic wait_mem(input logic row);
    int n = 0;
    while (!(mem_req === 1'b1 && mem_row === row) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("mem_req_timeout");
  endtask

  // CPU-side monitor
  always @(negedge clk) begin : cpu_mon
    cpu_exp_t e;
    if (rst_n && cpu_ready) begin
      if (cpu_q.size() == 0) begin
        fail_now("spurious_cpu_ready");
      end else begin
        e = cpu_q.pop_front();
        if (e.is_read) check("cpu_rdata", cpu_rdata, e.rdata);
        check("cpu_hit", cpu_hit, e.hit);
        check("hit_count", hit_count, e.hits);
        check("miss_count", miss_count, e.misses);
        if (e.hit) check("hit_latency", cyc - e.issue_cyc, 2);
      end
      done_cnt++;
    end
  end

  // Memory responder and memory-side monitor
  task automatic serve();
    logic         row;
    logic [9:0]   a;
    logic [127:0] wd;
    int           lat;
    bit           stable;
    mem_exp_t     m;
    row = mem_row;
    a = mem_addr;
    wd = mem_wdata;
    stable = 1'b1;
    if (mem_q.size() == 0) begin
      fail_now("unexpected_mem_req");
    end else begin
      m = mem_q.pop_front();
      check("mem_row", row, m.row);
      check("mem_addr", a, m.addr);
      if (m.row) check("mem_wdata", wd, m.wdata);
    end
    lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      if (!rst_n) return;
      if (mem_req !== 1'b1 || mem_addr !== a || mem_row !== row || (row && mem_wdata !== wd))
        stable = 1'b0;
    end
    check("mem_stable", stable, 1'b1);
    if (row) for (int k = 0; k < 16; k++) mem[int'(a) + k] = wd[8*k +: 8];
    else     mem_rdata = mem_line(int'(a));
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    forever begin
      if (rst_n && mem_req) serve();
      else @(negedge clk);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int target;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hA5;
    mem[1] = 8'h5A;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_cpu_ready", cpu_ready, 0);
    check("rst_cpu_hit", cpu_hit, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_row", mem_row, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_miss_count", miss_count, 0);
    rst_n = 1'b1;

    // cold read miss, then a hit on the same line
    txn(1'b0, 'h000, 8'h00);
    txn(1'b0, 'h001, 8'h00);

    // write-allocate into idx 1, then conflicting read forces a write-back
    txn(1'b1, 'h012, 8'h3C);
    txn(1'b0, 'h052, 8'h00);

    // slow memory during refill, with a stray cpu_req that must be ignored
    fixed_lat = 10;
    target = done_cnt + 1;
    issue(1'b0, 'h0A3, 8'h00);
    wait_mem(1'b0);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_row = 1'b1; cpu_addr = 10'h3FF; cpu_wdata = 8'hEE;
    repeat (2) @(posedge clk);
    #1 cpu_req = 1'b0;
    wait_done(target);
    fixed_lat = -1;

    // dirty idx 1 again, then reset in the middle of its write-back
    txn(1'b1, 'h012, 8'h77);
    fixed_lat = 20;
    issue(1'b0, 'h052, 8'h00);
    wait_mem(1'b1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_mem_req_drop", mem_req, 0);
    cpu_q.delete();
    mem_q.delete();
    model_reset();
    repeat (3) @(negedge clk);
    check("mid_rst_hit_count", hit_count, 0);
    check("mid_rst_miss_count", miss_count, 0);
    check("mid_rst_cpu_ready", cpu_ready, 0);
    rst_n = 1'b1;
    fixed_lat = -1;

    // lost dirty byte: refetch sees the earlier written-back 0x3C, no write-back
    txn(1'b0, 'h012, 8'h00);

    // saturate the hit counter
    for (int i = 0; i < 20; i++) txn(1'b0, 'h001, 8'h00);
    check("hit_count_saturated", hit_count, CNT_MAX);

    // randomized mix over a few tags so hits, clean and dirty misses all occur
    for (int i = 0; i < 400; i++)
      txn(1'($urandom_range(0, 1)), $urandom_range(0, 3) * 64 + $urandom_range(0, 63),
          8'($urandom));

    repeat (5) @(negedge clk);
    check("cpu_q_drained", cpu_q.size(), 0);
    check("mem_q_drained", mem_q.size(), 0);
    check("final_mem_req", mem_req, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
